// File: rtl/and_n.sv
`default_nettype none
// ============================================================================
// Module   : and_n
// Brief    : Parameterised bitwise AND with a combinational result and a
//            registered copy carrying zero/all-ones/popcount flags and a
//            one-cycle valid strobe.
// Revision : 1.0  initial release
// ============================================================================
module and_n #(
  parameter int N = 4,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  output logic [N-1:0]  S,
  input  logic          in_valid,
  output logic [N-1:0]  S_q,
  output logic          zero_q,
  output logic          ones_q,
  output logic [CW-1:0] count_q,
  output logic          out_valid
);

  logic [N-1:0]  w_and;
  logic [N-1:0]  s_d;
  logic          zero_d;
  logic          ones_d;
  logic [CW-1:0] count_d;

  // The combinational result feeds both S and the capture path, so the two
  // paths can never disagree on the function of A and B.
  assign w_and = A & B;
  assign S     = w_and;

  // Status values for the next capture, derived from the current result.
  always_comb begin
    s_d     = w_and;
    zero_d  = ~|w_and;
    ones_d  = &w_and;
    count_d = '0;
    for (int i = 0; i < N; i++) begin
      count_d = count_d + CW'(w_and[i]);
    end
  end

  // Registered path: reset wins over capture; data holds when idle while the
  // valid strobe follows in_valid with one cycle of latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S_q       <= '0;
      zero_q    <= 1'b0;
      ones_q    <= 1'b0;
      count_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S_q     <= s_d;
        zero_q  <= zero_d;
        ones_q  <= ones_d;
        count_q <= count_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_and_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_and_n
// Brief    : Self-checking bench for and_n (N = 4) against a behavioural
//            model of the registered result and its status flags.
// Revision : 1.0  initial release
// ============================================================================
module tb_and_n;

  localparam int N  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  A = '0;
  logic [N-1:0]  B = '0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  S;
  logic [N-1:0]  S_q;
  logic          zero_q;
  logic          ones_q;
  logic [CW-1:0] count_q;
  logic          out_valid;

  int checks = 0;
  int errors = 0;

  // Reference state of the registered outputs.
  logic [N-1:0]  m_sq;
  logic          m_zero;
  logic          m_ones;
  int            m_cnt;
  logic          m_ov;

  and_n #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .S(S), .in_valid(in_valid),
    .S_q(S_q), .zero_q(zero_q), .ones_q(ones_q), .count_q(count_q),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic int pop(input logic [N-1:0] v);
    int n = 0;
    for (int i = 0; i < N; i++) if (v[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic logic [N+CW+2:0] model_vec();
    logic [CW-1:0] c = CW'(m_cnt);
    return {m_sq, m_zero, m_ones, c, m_ov};
  endfunction

  // Advance one clock and update the model from what was driven at the edge.
  task automatic tick();
    logic [N-1:0] r;
    @(posedge clk);
    r = A & B;
    if (!rst_n) begin
      m_sq = '0; m_zero = 1'b0; m_ones = 1'b0; m_cnt = 0; m_ov = 1'b0;
    end else if (in_valid) begin
      m_sq = r; m_zero = (r == 0); m_ones = (r == {N{1'b1}});
      m_cnt = pop(r); m_ov = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; A = 4'hF; B = 4'hF;
    tick();
    checks++;
    if ({S_q, zero_q, ones_q, count_q, out_valid} !== '0) begin
      errors++;
      $display("FAIL reset_regs got %b want 0", {S_q, zero_q, ones_q, count_q, out_valid});
    end
    checks++;
    if (S !== 4'hF) begin
      errors++; $display("FAIL reset_S got %h want f", S);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [N-1:0]  ta [5] = '{4'h0, 4'hF, 4'h0, 4'hA, 4'hF};
    logic [N-1:0]  tb [5] = '{4'h0, 4'h6, 4'hF, 4'hF, 4'hF};
    logic [N-1:0]  ts [5] = '{4'h0, 4'h6, 4'h0, 4'hA, 4'hF};
    logic [CW-1:0] tc [5] = '{3'd0, 3'd2, 3'd0, 3'd2, 3'd4};
    logic          tz [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic          to [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      A = ta[i]; B = tb[i]; in_valid = 1'b1;
      #1;
      checks++;
      if (S !== ts[i]) begin
        errors++; $display("FAIL directed_S[%0d] got %h want %h", i, S, ts[i]);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if ({S_q, zero_q, ones_q, count_q, out_valid} !== {ts[i], tz[i], to[i], tc[i], 1'b1}) begin
        errors++;
        $display("FAIL directed_regs[%0d] got %b want %b", i,
                 {S_q, zero_q, ones_q, count_q, out_valid}, {ts[i], tz[i], to[i], tc[i], 1'b1});
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || S_q !== ts[i]) begin
        errors++;
        $display("FAIL directed_hold[%0d] got ov=%b sq=%h want ov=0 sq=%h", i, out_valid, S_q, ts[i]);
      end
    end
  endtask

  task automatic test_reset_hold();
    A = 4'hA; B = 4'hF; in_valid = 1'b1;
    tick();
    checks++;
    if (S_q !== 4'hA || out_valid !== 1'b1) begin
      errors++; $display("FAIL hold_capture got sq=%h ov=%b want sq=a ov=1", S_q, out_valid);
    end
    rst_n = 1'b0; in_valid = 1'b1; A = 4'h7; B = 4'hD;
    tick();
    checks++;
    if ({S_q, zero_q, ones_q, count_q, out_valid} !== '0) begin
      errors++;
      $display("FAIL hold_reset got %b want 0", {S_q, zero_q, ones_q, count_q, out_valid});
    end
    checks++;
    if (S !== 4'h5) begin
      errors++; $display("FAIL hold_reset_S got %h want 5", S);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = 4'($urandom); B = 4'($urandom);
      tick();
      checks++;
      if (S_q !== 4'h0 || out_valid !== 1'b0 || count_q !== 3'd0) begin
        errors++;
        $display("FAIL hold_idle[%0d] got sq=%h ov=%b cnt=%0d want 0", i, S_q, out_valid, count_q);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int v = 0; v < 256; v++) begin
      A = v[7:4]; B = v[3:0]; in_valid = 1'b1;
      #1;
      checks++;
      if (S !== (A & B)) begin
        errors++; $display("FAIL b2b_S[%0d] got %h want %h", v, S, A & B);
      end
      tick();
      checks++;
      if ({S_q, zero_q, ones_q, count_q, out_valid} !== model_vec()) begin
        errors++;
        $display("FAIL b2b_regs[%0d] got %b want %b", v,
                 {S_q, zero_q, ones_q, count_q, out_valid}, model_vec());
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      A = 4'($urandom); B = 4'($urandom);
      in_valid = 1'($urandom);
      rst_n = ($urandom_range(0, 15) != 0);
      #1;
      checks++;
      if (S !== (A & B)) begin
        errors++; $display("FAIL rand_S[%0d] got %h want %h", i, S, A & B);
      end
      tick();
      checks++;
      if ({S_q, zero_q, ones_q, count_q, out_valid} !== model_vec()) begin
        errors++;
        $display("FAIL rand_regs[%0d] got %b want %b", i,
                 {S_q, zero_q, ones_q, count_q, out_valid}, model_vec());
      end
    end
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  initial begin
    m_sq = '0; m_zero = 1'b0; m_ones = 1'b0; m_cnt = 0; m_ov = 1'b0;
    #2;
    test_reset();
    test_directed();
    test_reset_hold();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
